// File: rtl/hit_resolver_if.sv
// -----------------------------------------------------------------------------
// hit_resolver_if
// Purpose : groups the per-frame player inputs and the combat/round outputs
//           exchanged between the game logic and the hit resolver.
// Signals :
//   p1_state, p2_state   4b   sprite FSM state codes (game -> resolver)
//   p1_x, p2_x           10b  hurtbox left edges     (game -> resolver)
//   p1_got_hit/blocked   1b   one-cycle result pulses for player 1
//   p2_got_hit/blocked   1b   one-cycle result pulses for player 2
//   p1_wins, p2_wins     2b   round-win counters
//   freeze               1b   gameplay halted
//   round_restart        1b   one-cycle "return to start" pulse
//   match_over, winner   1b   sticky match end flag and winner (0 = P1)
// Modports: master = game logic side, slave = hit_resolver side.
// -----------------------------------------------------------------------------
interface hit_resolver_if;
    logic [3:0] p1_state;
    logic [3:0] p2_state;
    logic [9:0] p1_x;
    logic [9:0] p2_x;
    logic       p1_got_hit;
    logic       p1_got_blocked;
    logic       p2_got_hit;
    logic       p2_got_blocked;
    logic [1:0] p1_wins;
    logic [1:0] p2_wins;
    logic       freeze;
    logic       round_restart;
    logic       match_over;
    logic       winner;

    modport master (
        output p1_state, p2_state, p1_x, p2_x,
        input  p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
        input  p1_wins, p2_wins, freeze, round_restart, match_over, winner
    );

    modport slave (
        input  p1_state, p2_state, p1_x, p2_x,
        output p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
        output p1_wins, p2_wins, freeze, round_restart, match_over, winner
    );
endinterface

// File: rtl/hit_resolver.sv
// -----------------------------------------------------------------------------
// hit_resolver
// Purpose : per-frame combat resolution for a two-player fighter. Decides
//           whether an active attack frame connects, whether it is blocked,
//           keeps the round score and sequences round/match end.
// Ports   :
//   clk    in   frame clock, one rising edge per game frame
//   reset  in   synchronous, active-high reset
//   bus    hit_resolver_if.slave (player states/positions in, results out)
// Parameters:
//   BODY_W, ATK_REACH, DIRATK_REACH  geometry in pixels
//   ROUND_END_FRAMES                 freeze length after a round-winning hit
//   WINS_TO_MATCH                    round wins needed to take the match
// -----------------------------------------------------------------------------
module hit_resolver #(
    parameter int BODY_W           = 32,
    parameter int ATK_REACH        = 40,
    parameter int DIRATK_REACH     = 56,
    parameter int ROUND_END_FRAMES = 60,
    parameter int WINS_TO_MATCH    = 3
) (
    input  logic          clk,
    input  logic          reset,
    hit_resolver_if.slave bus
);

    // Top-level FSM encoding
    localparam logic [1:0] S_PLAY      = 2'd0;
    localparam logic [1:0] S_ROUND_END = 2'd1;
    localparam logic [1:0] S_MATCH_END = 2'd2;

    // Sprite state codes that matter here
    localparam logic [3:0] ST_BACKWARD  = 4'd1;
    localparam logic [3:0] ST_ATK_ACT   = 4'd4;
    localparam logic [3:0] ST_DIR_ACT   = 4'd7;
    localparam logic [3:0] ST_BLOCKSTUN = 4'd10;

    localparam int CNT_W = (ROUND_END_FRAMES < 2) ? 1 : $clog2(ROUND_END_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_END_FRAMES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p1_latch;
    logic             r_p2_latch;
    logic             r_p1_hit;
    logic             r_p1_blk;
    logic             r_p2_hit;
    logic             r_p2_blk;
    logic [1:0]       r_p1_wins;
    logic [1:0]       r_p2_wins;
    logic             r_restart;
    logic             r_winner;

    // ---------------------------------------------------------------------
    // Geometry: gap between P1's front edge and P2's hurtbox. Widened to
    // 11 bits and clamped at 0 so overlapping or crossed players never wrap.
    // ---------------------------------------------------------------------
    logic [10:0] w_p1_front;
    logic [10:0] w_p2_left;
    logic [10:0] w_gap;

    assign w_p1_front = {1'b0, bus.p1_x} + 11'(BODY_W);
    assign w_p2_left  = {1'b0, bus.p2_x};
    assign w_gap      = (w_p2_left > w_p1_front) ? (w_p2_left - w_p1_front) : 11'd0;

    // ---------------------------------------------------------------------
    // Connect / block detection
    // ---------------------------------------------------------------------
    logic w_p1_active, w_p2_active;
    logic w_p1_conn, w_p2_conn;
    logic w_p1_guard, w_p2_guard;
    logic w_p1_fire, w_p2_fire;
    logic w_hit_on_p1, w_blk_on_p1, w_hit_on_p2, w_blk_on_p2;

    assign w_p1_active = (bus.p1_state == ST_ATK_ACT) || (bus.p1_state == ST_DIR_ACT);
    assign w_p2_active = (bus.p2_state == ST_ATK_ACT) || (bus.p2_state == ST_DIR_ACT);

    assign w_p1_conn = ((bus.p1_state == ST_ATK_ACT) && (w_gap <= 11'(ATK_REACH))) ||
                       ((bus.p1_state == ST_DIR_ACT) && (w_gap <= 11'(DIRATK_REACH)));
    assign w_p2_conn = ((bus.p2_state == ST_ATK_ACT) && (w_gap <= 11'(ATK_REACH))) ||
                       ((bus.p2_state == ST_DIR_ACT) && (w_gap <= 11'(DIRATK_REACH)));

    // Holding back or already in blockstun counts as guarding
    assign w_p1_guard = (bus.p1_state == ST_BACKWARD) || (bus.p1_state == ST_BLOCKSTUN);
    assign w_p2_guard = (bus.p2_state == ST_BACKWARD) || (bus.p2_state == ST_BLOCKSTUN);

    // Connects are only evaluated during play and once per active window
    assign w_p1_fire = (r_state == S_PLAY) && w_p1_conn && !r_p1_latch;
    assign w_p2_fire = (r_state == S_PLAY) && w_p2_conn && !r_p2_latch;

    assign w_hit_on_p2 = w_p1_fire && !w_p2_guard;
    assign w_blk_on_p2 = w_p1_fire &&  w_p2_guard;
    assign w_hit_on_p1 = w_p2_fire && !w_p1_guard;
    assign w_blk_on_p1 = w_p2_fire &&  w_p1_guard;

    // ---------------------------------------------------------------------
    // Scoring: saturating counters, match decided against WINS_TO_MATCH
    // ---------------------------------------------------------------------
    logic [1:0] w_p1_wins_nxt, w_p2_wins_nxt;
    logic       w_p1_takes_match, w_p2_takes_match;

    assign w_p1_wins_nxt    = (r_p1_wins == 2'd3) ? 2'd3 : r_p1_wins + 2'd1;
    assign w_p2_wins_nxt    = (r_p2_wins == 2'd3) ? 2'd3 : r_p2_wins + 2'd1;
    assign w_p1_takes_match = 32'(w_p1_wins_nxt) >= WINS_TO_MATCH;
    assign w_p2_takes_match = 32'(w_p2_wins_nxt) >= WINS_TO_MATCH;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_PLAY;
            r_cnt      <= '0;
            r_p1_latch <= 1'b0;
            r_p2_latch <= 1'b0;
            r_p1_hit   <= 1'b0;
            r_p1_blk   <= 1'b0;
            r_p2_hit   <= 1'b0;
            r_p2_blk   <= 1'b0;
            r_p1_wins  <= 2'd0;
            r_p2_wins  <= 2'd0;
            r_restart  <= 1'b0;
            r_winner   <= 1'b0;
        end else begin
            // Pulses default low so they last exactly one frame
            r_p1_hit  <= 1'b0;
            r_p1_blk  <= 1'b0;
            r_p2_hit  <= 1'b0;
            r_p2_blk  <= 1'b0;
            r_restart <= 1'b0;

            // Latch drops the first frame the attacker leaves its active frame
            if (!w_p1_active)   r_p1_latch <= 1'b0;
            else if (w_p1_fire) r_p1_latch <= 1'b1;
            if (!w_p2_active)   r_p2_latch <= 1'b0;
            else if (w_p2_fire) r_p2_latch <= 1'b1;

            case (r_state)
                S_PLAY: begin
                    r_p1_hit <= w_hit_on_p1;
                    r_p1_blk <= w_blk_on_p1;
                    r_p2_hit <= w_hit_on_p2;
                    r_p2_blk <= w_blk_on_p2;
                    r_cnt    <= '0;
                    // A trade (both defenders hit) awards nothing
                    if (w_hit_on_p2 && !w_hit_on_p1) begin
                        r_p1_wins <= w_p1_wins_nxt;
                        if (w_p1_takes_match) begin
                            r_state  <= S_MATCH_END;
                            r_winner <= 1'b0;
                        end else begin
                            r_state  <= S_ROUND_END;
                        end
                    end else if (w_hit_on_p1 && !w_hit_on_p2) begin
                        r_p2_wins <= w_p2_wins_nxt;
                        if (w_p2_takes_match) begin
                            r_state  <= S_MATCH_END;
                            r_winner <= 1'b1;
                        end else begin
                            r_state  <= S_ROUND_END;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= S_PLAY;
                        r_cnt      <= '0;
                        r_restart  <= 1'b1;
                        r_p1_latch <= 1'b0;
                        r_p2_latch <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MATCH_END: begin
                    // Terminal until reset
                    r_state <= S_MATCH_END;
                end
                default: begin
                    r_state <= S_PLAY;
                end
            endcase
        end
    end

    assign bus.p1_got_hit     = r_p1_hit;
    assign bus.p1_got_blocked = r_p1_blk;
    assign bus.p2_got_hit     = r_p2_hit;
    assign bus.p2_got_blocked = r_p2_blk;
    assign bus.p1_wins        = r_p1_wins;
    assign bus.p2_wins        = r_p2_wins;
    assign bus.freeze         = (r_state != S_PLAY);
    assign bus.round_restart  = r_restart;
    assign bus.match_over     = (r_state == S_MATCH_END);
    assign bus.winner         = r_winner;

endmodule

// File: tb/tb_hit_resolver.sv
// -----------------------------------------------------------------------------
// tb_hit_resolver
// Purpose : self-checking bench for hit_resolver. The stimulus process pushes
//           expected output events (with the frame they must appear on) into a
//           queue; a negedge monitor pops and compares whenever the DUT shows a
//           result pulse or round_restart. Level checks cover reset, freeze
//           length and match hold.
// -----------------------------------------------------------------------------
module tb_hit_resolver;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    hit_resolver_if bus ();

    hit_resolver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {p1_hit, p1_blk, p2_hit, p2_blk}, restart, p1_wins, p2_wins, freeze, match_over, winner
    typedef struct packed {
        logic [3:0] pulses;
        logic       rr;
        logic [1:0] w1;
        logic [1:0] w2;
        logic       frz;
        logic       mo;
        logic       win;
    } ev_t;

    ev_t exp_q[$];
    int  cyc_q[$];

    function automatic ev_t snap();
        ev_t e;
        e.pulses = {bus.p1_got_hit, bus.p1_got_blocked, bus.p2_got_hit, bus.p2_got_blocked};
        e.rr     = bus.round_restart;
        e.w1     = bus.p1_wins;
        e.w2     = bus.p2_wins;
        e.frz    = bus.freeze;
        e.mo     = bus.match_over;
        e.win    = bus.winner;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] p, input logic rr,
                             input logic [1:0] w1, input logic [1:0] w2,
                             input logic frz, input logic mo, input logic win);
        ev_t e;
        e.pulses = p; e.rr = rr; e.w1 = w1; e.w2 = w2;
        e.frz = frz; e.mo = mo; e.win = win;
        exp_q.push_back(e);
        cyc_q.push_back(at);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any visible pulse must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        int  c;
        act = snap();
        if (act.pulses != 4'd0 || act.rr) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %h at cyc %0d, nothing expected", act, cyc);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                if (act != e || cyc != c) begin
                    n_fail++;
                    $display("FAIL event: got %h at cyc %0d, expected %h at cyc %0d", act, cyc, e, c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nf;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        bus.p1_x     = 10'd100;
        bus.p2_x     = 10'd400;
        step(3);
        chk("reset_state", int'(snap()), 0);
        reset = 1'b0;
        step(2);

        // Basic attack, gap 28, undefended: hit, round end, restart
        bus.p2_x = 10'd160;
        bus.p1_state = 4'd4;
        expect_ev(cyc + 1,  4'b0010, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        expect_ev(cyc + 61, 4'b0000, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        nf = 0;
        for (int i = 0; i < 70; i++) begin
            step(1);
            if (i == 0) bus.p1_state = 4'd4;
            if (i == 1) bus.p1_state = 4'd5;
            if (i == 2) bus.p1_state = 4'd0;
            nf += int'(bus.freeze);
        end
        chk("freeze_len", nf, 60);

        // Same geometry, defender walking back: blocked, no score, no freeze
        bus.p2_state = 4'd1;
        bus.p1_state = 4'd4;
        expect_ev(cyc + 1, 4'b0001, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (i == 1) bus.p1_state = 4'd0;
            nf += int'(bus.freeze);
        end
        chk("block_no_freeze", nf, 0);

        // Reach boundary against blockstun: gap 41 misses, gap 40 connects
        bus.p2_state = 4'd10;
        bus.p2_x = 10'd173;
        bus.p1_state = 4'd4;
        step(3);
        bus.p2_x = 10'd172;
        expect_ev(cyc + 1, 4'b0001, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        bus.p1_state = 4'd0;
        step(1);

        // Crossed players clamp gap to 0 instead of wrapping
        bus.p1_x = 10'd500;
        bus.p2_x = 10'd100;
        bus.p1_state = 4'd4;
        expect_ev(cyc + 1, 4'b0001, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        bus.p1_x = 10'd100;
        step(1);

        // Directional attack: gap 68 out of reach, gap 48 connects
        bus.p2_x = 10'd200;
        bus.p1_state = 4'd7;
        step(3);
        bus.p2_x = 10'd180;
        expect_ev(cyc + 1,  4'b0010, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0);
        expect_ev(cyc + 61, 4'b0000, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        bus.p1_state = 4'd8;
        step(1);
        bus.p1_state = 4'd0;
        step(65);

        // Trade at gap 10: both hit, no score, stays in play
        bus.p2_x = 10'd142;
        bus.p1_state = 4'd4;
        bus.p2_state = 4'd4;
        expect_ev(cyc + 1, 4'b1010, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        bus.p1_state = 4'd5;
        bus.p2_state = 4'd5;
        step(1);
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        step(2);

        // Third P1 hit takes the match
        bus.p2_x = 10'd160;
        bus.p1_state = 4'd4;
        expect_ev(cyc + 1, 4'b0010, 1'b0, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1);
        bus.p1_state = 4'd0;
        step(1);
        // Further attacks from either side are ignored
        nf = 0;
        for (int i = 0; i < 12; i++) begin
            bus.p1_state = (i % 2 == 0) ? 4'd4 : 4'd0;
            bus.p2_state = (i % 3 == 0) ? 4'd4 : 4'd0;
            step(1);
            nf += int'(bus.match_over && bus.freeze && !bus.winner);
        end
        chk("match_hold", nf, 12);
        chk("match_wins", int'(bus.p1_wins), 3);
        bus.p1_state = 4'd0;
        bus.p2_state = 4'd0;
        reset = 1'b1;
        step(1);
        chk("reset_after_match", int'(snap()), 0);
        reset = 1'b0;
        step(2);

        // P2 directional hit, then reset at frame 30 of the freeze
        bus.p2_x = 10'd180;
        bus.p2_state = 4'd7;
        expect_ev(cyc + 1, 4'b1000, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        bus.p2_state = 4'd8;
        step(1);
        bus.p2_state = 4'd0;
        step(28);
        chk("freeze_mid_round", int'(bus.freeze), 1);
        reset = 1'b1;
        step(1);
        chk("reset_mid_round", int'(snap()), 0);
        reset = 1'b0;
        nf = 0;
        for (int i = 0; i < 70; i++) begin
            step(1);
            nf += int'(bus.freeze);
        end
        chk("no_freeze_after_reset", nf, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 Parameter BODY_W, default 32, meaning hurtbox width in pixels for each player.
REQ-002 Parameter ATK_REACH, default 40, meaning basic-attack reach in pixels beyond the attacker's front edge.
REQ-003 Parameter DIRATK_REACH, default 56, meaning directional-attack reach in pixels beyond the attacker's front edge.
REQ-004 Parameter ROUND_END_FRAMES, default 60, meaning freeze length in frames after a round-winning hit.
REQ-005 Parameter WINS_TO_MATCH, default 3, meaning round wins needed to win the match.
REQ-006 clk  input  1  frame clock; one rising edge per game frame.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 p1_state  input  4  player-1 sprite FSM state code.
REQ-009 p2_state  input  4  player-2 sprite FSM state code.
REQ-010 p1_x  input  10  player-1 hurtbox left edge; player 1 faces right.
REQ-011 p2_x  input  10  player-2 hurtbox left edge; player 2 faces left.
REQ-012 p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked  output  1 each  registered one-cycle pulses driving each player's FSM.
REQ-013 p1_wins, p2_wins  output  2 each  round-win counters.
REQ-014 freeze  output  1  high while gameplay is halted.
REQ-015 round_restart  output  1  one-cycle pulse telling position and sprite logic to return to start.
REQ-016 match_over  output  1  sticky match-end flag.
REQ-017 winner  output  1  match winner: 0 = player 1, 1 = player 2; valid only while match_over is high.

Function
REQ-018 State codes: 0 IDLE, 1 BACKWARD, 2 FORWARD, 3-5 ATTACK start/active/recovery, 6-8 DIRATK start/active/recovery, 9 HITSTUN, 10 BLOCKSTUN.
REQ-019 gap SHALL be computed in 11 bits as p2_x - (p1_x + BODY_W) when p2_x > p1_x + BODY_W, else 0; it SHALL never wrap.
REQ-020 P1 connects when p1_state is 4 and gap <= ATK_REACH, or when p1_state is 7 and gap <= DIRATK_REACH; P2 connects by the same rule using p2_state and the same gap.
REQ-021 A connecting attack SHALL produce a blocked result if the defender's state is 1 or 10, and a hit result otherwise.
REQ-022 Each player SHALL own a connected latch; a connect is honoured only while the latch is clear.
- The latch sets on connect.
- The latch clears on the first cycle the attacker's state is neither 4 nor 7.
- Result: at most one result per active window.
REQ-023 Result pulses SHALL assert on the clock edge following the qualifying cycle (1-cycle latency) and last exactly one cycle.
REQ-024 The top-level FSM SHALL have states PLAY, ROUND_END and MATCH_END.
REQ-025 In PLAY, a hit on exactly one defender SHALL increment the attacker's win counter on the same edge as the pulse.
- If the counter reaches WINS_TO_MATCH: go to MATCH_END.
- Otherwise: go to ROUND_END.
REQ-026 Simultaneous connects (trade) SHALL deliver both result pulses, award no win and stay in PLAY.
REQ-027 Blocked results SHALL never change the win counters or the FSM state.
REQ-028 ROUND_END SHALL hold freeze=1 for ROUND_END_FRAMES cycles, then pulse round_restart for one cycle, clear both latches and return to PLAY with freeze=0.
REQ-029 In ROUND_END and MATCH_END, all result pulses SHALL be suppressed and no connect SHALL be evaluated.
REQ-030 MATCH_END SHALL hold freeze=1 and match_over=1 with winner valid until reset; counters SHALL saturate and never wrap.

Reset
REQ-031 On reset: state PLAY, all pulses 0, win counters 0, freeze 0, round_restart 0, match_over 0, winner 0, latches clear, freeze counter 0.
REQ-032 Reset asserted in any state, including mid-ROUND_END or MATCH_END, SHALL take effect on the next edge with no residual pulse.

Verification
REQ-033 p1_x=100, p2_x=160, p1_state=4 for 2 cycles, p2_state=0 -> gap=28; p2_got_hit=1 for exactly one cycle, one edge after the first active cycle; p1_wins=1; freeze=1 for 60 cycles; round_restart pulse; back to PLAY.
REQ-034 Same geometry with p2_state=1 -> p2_got_blocked pulse once, p1_wins unchanged, freeze stays 0.
REQ-035 p1_x=100, p2_x=200 (gap=68), p1_state=7 -> no pulse; p2_x=180 (gap=48), p1_state=7 -> p2_got_hit.
REQ-036 Both states 4 at gap=10 on the same cycle -> p1_got_hit and p2_got_hit pulse together, both counters unchanged, FSM stays in PLAY.
REQ-037 p1 lands three unblocked hits across rounds -> p1_wins=3, match_over=1, winner=0; further p1_state=4 connects produce no pulses; reset clears all outputs to 0.
REQ-038 Reset asserted at frame 30 of ROUND_END -> next cycle freeze=0, no round_restart pulse, counters 0.
